// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   scan_state_t   - scanner FSM states
//   KEY_MAP        - 16-entry hex code table indexed by {row, col}
//   onehot_to_idx  - 4-bit one-hot to 2-bit index
//   is_onehot4     - true when exactly one of four bits is set
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Physical legend, row by row (top to bottom), column left to right:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync.sv
// sync_2ff: two-stage synchronizer for asynchronous level inputs.
//   clk   - destination clock
//   reset - synchronous, active-high; clears both stages
//   d     - asynchronous input bus (WIDTH bits)
//   q     - synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row-scanning controller for a 4x4 matrix keypad.
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   cols      - raw column lines (async, active-high), cols[i] = column i
//   rows      - one-hot active-high row drive, rows[j] = row j
//   key_code  - hex code of the most recently accepted key
//   key_valid - one-cycle pulse when a key press is accepted
//   key_held  - high from acceptance until the release is debounced
// Rows are driven one at a time; a single key seen at the end of a row's
// dwell is debounced on press and on release, producing one event per press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV        = 16'd1000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  logic [3:0]  csync;

  scan_state_t state_reg,     state_next;
  logic [15:0] dwell_reg,     dwell_next;
  logic [15:0] deb_cnt_reg,   deb_cnt_next;
  logic [3:0]  rows_reg,      rows_next;
  logic [1:0]  row_idx_reg,   row_idx_next;
  logic [3:0]  col_mask_reg,  col_mask_next;
  logic [3:0]  key_code_reg,  key_code_next;
  logic        key_valid_reg, key_valid_next;
  logic        key_held_reg,  key_held_next;

  logic [3:0]  rows_rotated;
  logic        col_active;

  sync_2ff #(.WIDTH(4)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (csync)
  );

  assign rows_rotated = {rows_reg[2:0], rows_reg[3]};
  // Only the latched column matters once a key is held; other columns
  // are deliberately ignored so a second key cannot generate an event.
  assign col_active   = |(csync & col_mask_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SCAN;
      dwell_reg     <= '0;
      deb_cnt_reg   <= '0;
      rows_reg      <= 4'b0001;
      row_idx_reg   <= '0;
      col_mask_reg  <= '0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dwell_reg     <= dwell_next;
      deb_cnt_reg   <= deb_cnt_next;
      rows_reg      <= rows_next;
      row_idx_reg   <= row_idx_next;
      col_mask_reg  <= col_mask_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    dwell_next     = dwell_reg;
    deb_cnt_next   = deb_cnt_reg;
    rows_next      = rows_reg;
    row_idx_next   = row_idx_reg;
    col_mask_next  = col_mask_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    case (state_reg)
      SCAN: begin
        if (dwell_reg == SCAN_DIV - 16'd1) begin
          dwell_next = '0;
          if (is_onehot4(csync)) begin
            // Exactly one key on this row: freeze rows and start debouncing.
            row_idx_next  = onehot_to_idx(rows_reg);
            col_mask_next = csync;
            deb_cnt_next  = '0;
            state_next    = DEBOUNCE;
          end else begin
            rows_next = rows_rotated;
          end
        end else begin
          dwell_next = dwell_reg + 16'd1;
        end
      end

      DEBOUNCE: begin
        if (csync == col_mask_reg) begin
          if (deb_cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
            key_valid_next = 1'b1;
            key_held_next  = 1'b1;
            key_code_next  = KEY_MAP[{row_idx_reg, onehot_to_idx(col_mask_reg)}];
            state_next     = HELD;
          end else begin
            deb_cnt_next = deb_cnt_reg + 16'd1;
          end
        end else begin
          // Bounce or a second key appeared: abandon without an event.
          rows_next  = rows_rotated;
          dwell_next = '0;
          state_next = SCAN;
        end
      end

      HELD: begin
        if (!col_active) begin
          deb_cnt_next = '0;
          state_next   = RELEASE;
        end
      end

      RELEASE: begin
        if (col_active) begin
          state_next = HELD;
        end else if (deb_cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
          key_held_next = 1'b0;
          rows_next     = rows_rotated;
          dwell_next    = '0;
          state_next    = SCAN;
        end else begin
          deb_cnt_next = deb_cnt_reg + 16'd1;
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

  assign rows      = rows_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with a fast scan/debounce setup.
// A behavioural keypad model drives cols from rows; a reference model of
// the scanning rules is compared against the DUT on every cycle, and
// directed scenarios add literal expectations.
module tb_keypad_scan_ctrl;

  localparam int SD  = 4;
  localparam int DEB = 8;

  logic       clk;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [1:0] press_row;
  logic [3:0] press_mask;

  int check_count;
  int pass_count;
  int pulse_count;

  keypad_scan_ctrl #(
    .SCAN_DIV        (16'd4),
    .DEBOUNCE_CYCLES (16'd8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: the pressed contacts connect only while their row is driven.
  assign cols = (rows == (4'b0001 << press_row)) ? press_mask : 4'b0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 scanning, 1 confirming press, 2 holding, 3 confirming release.
  string      keys = "123A456B789CE0FD";
  bit         model_ready;
  int         m_phase, m_row, m_dwell, m_run, m_lrow, m_lcol;
  logic [3:0] m_pipe1, m_pipe2, m_lmask, m_code;
  bit         m_valid, m_held;

  function automatic logic [3:0] legend(input int idx);
    byte c;
    c = keys[idx];
    if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
    return 4'(c - 8'h41 + 10);
  endfunction

  task automatic model_step();
    logic [3:0] seen;
    if (reset) begin
      model_ready = 1;
      m_phase = 0; m_row = 0; m_dwell = 0; m_run = 0;
      m_pipe1 = 0; m_pipe2 = 0; m_code = 0; m_valid = 0; m_held = 0;
      m_lrow = 0; m_lcol = 0; m_lmask = 0;
      return;
    end
    if (!model_ready) return;
    seen    = m_pipe2;
    m_pipe2 = m_pipe1;
    m_pipe1 = cols;
    m_valid = 0;
    if (m_phase == 0) begin
      if (m_dwell == SD - 1) begin
        m_dwell = 0;
        if ($countones(seen) == 1) begin
          m_lrow = m_row; m_lmask = seen; m_run = 0; m_phase = 1;
          for (int i = 0; i < 4; i++) if (seen[i]) m_lcol = i;
        end else m_row = (m_row + 1) % 4;
      end else m_dwell++;
    end else if (m_phase == 1) begin
      if (seen == m_lmask) begin
        m_run++;
        if (m_run == DEB) begin
          m_valid = 1; m_held = 1; m_phase = 2;
          m_code = legend(m_lrow * 4 + m_lcol);
        end
      end else begin
        m_phase = 0; m_row = (m_row + 1) % 4; m_dwell = 0;
      end
    end else if (m_phase == 2) begin
      if (seen[m_lcol] == 1'b0) begin m_phase = 3; m_run = 0; end
    end else begin
      if (seen[m_lcol] == 1'b1) m_phase = 2;
      else begin
        m_run++;
        if (m_run == DEB) begin
          m_phase = 0; m_held = 0; m_row = (m_row + 1) % 4; m_dwell = 0;
        end
      end
    end
  endtask

  initial begin
    model_ready = 0;
    pulse_count = 0;
    forever begin
      @(posedge clk);
      if (key_valid === 1'b1) pulse_count++;
      model_step();
    end
  end

  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (model_ready) begin
        check("rows", rows, 32'(1 << m_row));
        check("key_code", key_code, m_code);
        check("key_valid", key_valid, m_valid);
        check("key_held", key_held, m_held);
        check("valid_repeat", prev_valid & key_valid, 0);
        prev_valid = key_valid;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_rows(input logic [3:0] val, input bit want_equal);
    int n;
    n = 0;
    while (((rows == val) != want_equal) && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_rows_timeout", 32'(n >= 64), 0);
  endtask

  task automatic set_key(input logic [1:0] r, input logic [3:0] m);
    press_row  = r;
    press_mask = m;
  endtask

  initial begin
    int p0;
    check_count = 0;
    pass_count  = 0;
    reset = 1'b1;
    set_key(2'd0, 4'b0000);

    // Reset state and free-running scan
    repeat (3) @(negedge clk);
    check("rst_rows", rows, 4'b0001);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 0);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("scan_rows", rows, 32'(1 << ((k / 4) % 4)));
    end

    // Press '5' for 200 cycles
    p0 = pulse_count;
    set_key(2'd1, 4'b0010);
    repeat (200) @(negedge clk);
    check("k5_pulses", pulse_count - p0, 1);
    check("k5_code", key_code, 4'h5);
    check("k5_held", key_held, 1);
    check("k5_rows", rows, 4'b0010);
    set_key(2'd1, 4'b0000);
    repeat (20) @(negedge clk);
    check("k5_released", key_held, 0);

    // Bounce on 'D': 7 matches in debounce, then gone
    p0 = pulse_count;
    wait_rows(4'b1000, 0);
    wait_rows(4'b1000, 1);
    set_key(2'd3, 4'b1000);
    repeat (9) @(negedge clk);
    set_key(2'd3, 4'b0000);
    repeat (30) @(negedge clk);
    check("bounce_pulses", pulse_count - p0, 0);
    check("bounce_code", key_code, 4'h5);
    check("bounce_held", key_held, 0);

    // '9' with a 3-cycle release glitch, then a second press
    p0 = pulse_count;
    set_key(2'd2, 4'b0100);
    repeat (40) @(negedge clk);
    check("k9_pulses", pulse_count - p0, 1);
    check("k9_code", key_code, 4'h9);
    check("k9_held", key_held, 1);
    set_key(2'd2, 4'b0000);
    repeat (3) @(negedge clk);
    set_key(2'd2, 4'b0100);
    repeat (20) @(negedge clk);
    check("glitch_held", key_held, 1);
    check("glitch_pulses", pulse_count - p0, 1);
    set_key(2'd2, 4'b0000);
    repeat (30) @(negedge clk);
    check("k9_released", key_held, 0);
    set_key(2'd2, 4'b0100);
    repeat (40) @(negedge clk);
    check("k9b_pulses", pulse_count - p0, 2);
    check("k9b_code", key_code, 4'h9);
    set_key(2'd2, 4'b0000);
    repeat (30) @(negedge clk);

    // Multi-key on row0, then 'A' held with '1' added
    p0 = pulse_count;
    set_key(2'd0, 4'b0011);
    repeat (40) @(negedge clk);
    check("multi_pulses", pulse_count - p0, 0);
    check("multi_held", key_held, 0);
    set_key(2'd0, 4'b1000);
    repeat (40) @(negedge clk);
    check("kA_pulses", pulse_count - p0, 1);
    check("kA_code", key_code, 4'hA);
    set_key(2'd0, 4'b1001);
    repeat (40) @(negedge clk);
    check("kA1_pulses", pulse_count - p0, 1);
    check("kA1_held", key_held, 1);
    check("kA1_code", key_code, 4'hA);
    set_key(2'd0, 4'b0000);
    repeat (30) @(negedge clk);

    // Reset in the middle of debouncing '0'
    p0 = pulse_count;
    wait_rows(4'b1000, 0);
    wait_rows(4'b1000, 1);
    set_key(2'd3, 4'b0010);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_rows", rows, 4'b0001);
    check("midrst_valid", key_valid, 0);
    check("midrst_code", key_code, 4'h0);
    check("midrst_held", key_held, 0);
    check("midrst_pulses", pulse_count - p0, 0);
    reset = 1'b0;
    set_key(2'd3, 4'b0000);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
